// File: rtl/side_road_sensor_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the main/side-road traffic light controller and its
// side-road sensor conditioner.
//   req_state_e : request FSM states (IDLE=0, REQ=1, GAP=2)
//   light_e     : one-hot light colour codes (RED, YELLOW, GREEN)
//   ctrWidth    : smallest counter width able to hold a given maximum value
// No ports (package).
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } req_state_e;

  typedef enum logic [2:0] {
    RED    = 3'b100,
    YELLOW = 3'b010,
    GREEN  = 3'b001
  } light_e;

  // Width needed for a counter that must reach maxVal; never less than 1 bit.
  function automatic int ctrWidth(input int maxVal);
    int w;
    w = 1;
    while ((1 << w) <= maxVal) w++;
    return w;
  endfunction

endpackage

// File: rtl/side_road_sensor_conditioner_if.sv
// ---------------------------------------------------------------------------
// side_road_sensor_conditioner_if
// Bundles the sensor-side inputs and the controller-side outputs of the
// side-road sensor conditioner.
//   raw_sense  : asynchronous loop-detector output, 1 = vehicle present
//   side_green : side-road green from the controller
//   Dss        : registered side-road request to the controller
//   veh_cnt    : waiting side-road vehicles (CNT_W bits)
//   fault      : sticky stuck-sensor flag
// Modports: master drives the inputs and observes outputs; slave is the
// conditioner itself.
// ---------------------------------------------------------------------------
interface side_road_sensor_conditioner_if #(
  parameter int CNT_W = 4
);

  logic             raw_sense;
  logic             side_green;
  logic             Dss;
  logic [CNT_W-1:0] veh_cnt;
  logic             fault;

  modport master (
    output raw_sense,
    output side_green,
    input  Dss,
    input  veh_cnt,
    input  fault
  );

  modport slave (
    input  raw_sense,
    input  side_green,
    output Dss,
    output veh_cnt,
    output fault
  );

endinterface

// File: rtl/side_road_sensor_conditioner_sense_debounce.sv
// ---------------------------------------------------------------------------
// sense_debounce
// Two-flop synchroniser followed by a stability debouncer for the raw
// side-road loop-detector signal.
//   clk       in  : system clock
//   Dreset    in  : synchronous active-high reset
//   raw_sense in  : asynchronous detector output
//   det_q     out : debounced detector level
//   rise      out : one-cycle pulse on the cycle det_q first reads 1
// The debounced level only changes after DEBOUNCE_CYC consecutive
// synchronised samples disagree with it, so shorter glitches vanish.
// ---------------------------------------------------------------------------
module sense_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic Dreset,
  input  logic raw_sense,
  output logic det_q,
  output logic rise
);

  localparam int CW = ctrWidth(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] stable_q;

  // Synchronise, count consecutive disagreeing samples, and flip the level
  // once enough have been seen. rise is registered alongside det_q so the
  // arrival pulse lines up with the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (Dreset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= '0;
      det_q    <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync1_q <= raw_sense;
      sync2_q <= sync1_q;
      rise    <= 1'b0;
      if (sync2_q == det_q) begin
        stable_q <= '0;
      end else if (stable_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_q <= '0;
        det_q    <= sync2_q;
        rise     <= sync2_q;
      end else begin
        stable_q <= stable_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/side_road_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// side_road_sensor_conditioner
// Produces the side-road request Dss for the traffic light controller from a
// raw loop-detector signal: debounces the detector, counts waiting vehicles
// (saturating), retires one vehicle per DEPART_CYC cycles of side green, and
// drives Dss through a request FSM with a minimum hold and a minimum gap.
//   clk    in  : system clock
//   Dreset in  : synchronous active-high reset
//   bus    slave modport of side_road_sensor_conditioner_if
//          (raw_sense, side_green in; Dss, veh_cnt, fault out)
// Build option SENSOR_FAULT_DET_EN: when defined, a stuck-high detector
// raises a sticky fault after STUCK_CYC consecutive high cycles of the
// debounced level; fault suppresses arrivals, clears the count and withholds
// requests. When undefined, fault is tied to 0 and no stuck counter exists.
// ---------------------------------------------------------------------------
module side_road_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int DEPART_CYC   = 8,
  parameter int MIN_HOLD     = 16,
  parameter int MIN_GAP      = 32,
  parameter int CNT_W        = 4
`ifdef SENSOR_FAULT_DET_EN
  ,
  parameter int STUCK_CYC    = 256
`endif
) (
  input  logic                          clk,
  input  logic                          Dreset,
  side_road_sensor_conditioner_if.slave bus
);

  localparam int DW      = ctrWidth(DEPART_CYC - 1);
  localparam int TMR_MAX = (MIN_GAP > MIN_HOLD) ? (MIN_GAP - 1) : (MIN_HOLD - 1);
  localparam int TW      = ctrWidth(TMR_MAX);

  logic             detQ;
  logic             rise;
  logic             arrival;
  logic             depart;
  logic             faultAct;
  logic [CNT_W-1:0] vehCnt_q;
  logic [CNT_W-1:0] vehCnt_d;
  logic [DW-1:0]    depTmr_q;
  logic [DW-1:0]    depTmr_d;
  req_state_e       state_q;
  logic [TW-1:0]    fsmTmr_q;
  logic             dss_q;

  sense_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .Dreset   (Dreset),
    .raw_sense(bus.raw_sense),
    .det_q    (detQ),
    .rise     (rise)
  );

  // Departure timer only runs while there is someone to depart; it wraps on
  // the departure cycle so each vehicle needs a fresh DEPART_CYC run.
  always_comb begin
    depTmr_d = '0;
    depart   = 1'b0;
    if (bus.side_green && (vehCnt_q != '0)) begin
      if (depTmr_q == DW'(DEPART_CYC - 1)) begin
        depart = 1'b1;
      end else begin
        depTmr_d = depTmr_q + 1'b1;
      end
    end
  end

  // Arrival and departure on the same cycle cancel out.
  always_comb begin
    arrival  = rise & ~faultAct;
    vehCnt_d = vehCnt_q;
    if (faultAct) begin
      vehCnt_d = '0;
    end else if (arrival && !depart) begin
      if (vehCnt_q != '1) vehCnt_d = vehCnt_q + 1'b1;
    end else if (depart && !arrival) begin
      vehCnt_d = vehCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Dreset) begin
      vehCnt_q <= '0;
      depTmr_q <= '0;
    end else begin
      vehCnt_q <= vehCnt_d;
      depTmr_q <= depTmr_d;
    end
  end

  // Request FSM. The timer restarts on every state entry; in REQ it
  // saturates at the hold limit so a long request cannot wrap it.
  always_ff @(posedge clk) begin
    if (Dreset) begin
      state_q  <= IDLE;
      fsmTmr_q <= '0;
      dss_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!faultAct && (vehCnt_q != '0)) begin
            state_q  <= REQ;
            fsmTmr_q <= '0;
            dss_q    <= 1'b1;
          end
        end
        REQ: begin
          if (faultAct || ((fsmTmr_q >= TW'(MIN_HOLD - 1)) && (vehCnt_q == '0))) begin
            state_q  <= GAP;
            fsmTmr_q <= '0;
            dss_q    <= 1'b0;
          end else if (fsmTmr_q < TW'(MIN_HOLD - 1)) begin
            fsmTmr_q <= fsmTmr_q + 1'b1;
          end
        end
        GAP: begin
          if (fsmTmr_q == TW'(MIN_GAP - 1)) begin
            state_q  <= IDLE;
            fsmTmr_q <= '0;
          end else begin
            fsmTmr_q <= fsmTmr_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          fsmTmr_q <= '0;
          dss_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SENSOR_FAULT_DET_EN
  localparam int SW = ctrWidth(STUCK_CYC - 1);

  logic [SW-1:0] stuckCnt_q;
  logic          fault_q;

  // Counts consecutive high cycles of the debounced level; the flag is
  // sticky and only a reset clears it.
  always_ff @(posedge clk) begin
    if (Dreset) begin
      stuckCnt_q <= '0;
      fault_q    <= 1'b0;
    end else if (!detQ) begin
      stuckCnt_q <= '0;
    end else if (stuckCnt_q == SW'(STUCK_CYC - 1)) begin
      fault_q <= 1'b1;
    end else begin
      stuckCnt_q <= stuckCnt_q + 1'b1;
    end
  end

  assign faultAct = fault_q;
`else
  assign faultAct = 1'b0;
`endif

  assign bus.Dss     = dss_q;
  assign bus.veh_cnt = vehCnt_q;
  assign bus.fault   = faultAct;

endmodule

// File: tb/tb_side_road_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_side_road_sensor_conditioner
// Self-checking bench for side_road_sensor_conditioner: a latency vector
// table, hand-written corner sequences and a randomized run, all compared
// against a behavioural model of the conditioner.
// ---------------------------------------------------------------------------
module tb_side_road_sensor_conditioner;

  localparam int CNT_W   = 4;
  localparam int VEH_MAX = 15;
  localparam int DEB     = 4;
  localparam int DEPART  = 8;
  localparam int HOLD    = 16;
  localparam int GAPLEN  = 32;
  localparam int STUCK   = 256;
`ifdef SENSOR_FAULT_DET_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_GAP  = 2;

  logic clk = 1'b0;
  logic Dreset;

  int checks = 0;
  int errors = 0;

  side_road_sensor_conditioner_if #(.CNT_W(CNT_W)) bus ();

  side_road_sensor_conditioner #(
    .DEBOUNCE_CYC(DEB),
    .DEPART_CYC  (DEPART),
    .MIN_HOLD    (HOLD),
    .MIN_GAP     (GAPLEN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .Dreset(Dreset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw sample history, debounced level, vehicle count,
  // request phase with entry stamp, stuck-high run.
  bit rawHist[6];
  bit mDet;
  bit mRisePrev;
  bit mFault;
  int mGreenRun;
  int mVeh;
  int mHighRun;
  int mPhase;
  int mCycle = 0;
  int mEntered;

  task automatic modelReset();
    for (int j = 0; j < 6; j++) rawHist[j] = 1'b0;
    mDet      = 1'b0;
    mRisePrev = 1'b0;
    mFault    = 1'b0;
    mGreenRun = 0;
    mVeh      = 0;
    mHighRun  = 0;
    mPhase    = PH_IDLE;
    mEntered  = mCycle;
  endtask

  // Advances the model by one clock edge using the inputs sampled there.
  task automatic modelEdge();
    bit allDiff;
    bit dep;
    bit arr;
    int newRun;
    int newVeh;
    int timer;
    int newPhase;
    int newEntered;
    int newHigh;
    bit newFault;
    bit newDet;
    bit newRise;
    mCycle++;
    if (Dreset) begin
      modelReset();
    end else begin
      // level flips once the last DEB synchronised samples all disagree
      allDiff = 1'b1;
      for (int j = 1; j <= DEB; j++) if (rawHist[j] == mDet) allDiff = 1'b0;
      newDet  = allDiff ? ~mDet : mDet;
      newRise = allDiff && !mDet;

      dep = 1'b0;
      newRun = 0;
      if (bus.side_green && mVeh > 0) begin
        newRun = mGreenRun + 1;
        if (newRun == DEPART) begin
          dep = 1'b1;
          newRun = 0;
        end
      end

      arr = mRisePrev && !mFault;
      if (mFault) newVeh = 0;
      else if (arr && !dep) newVeh = (mVeh < VEH_MAX) ? mVeh + 1 : mVeh;
      else if (dep && !arr) newVeh = mVeh - 1;
      else newVeh = mVeh;

      timer = mCycle - 1 - mEntered;
      newPhase = mPhase;
      newEntered = mEntered;
      if (mPhase == PH_IDLE && !mFault && mVeh != 0) begin
        newPhase = PH_REQ;
        newEntered = mCycle;
      end else if (mPhase == PH_REQ && (mFault || (timer >= HOLD - 1 && mVeh == 0))) begin
        newPhase = PH_GAP;
        newEntered = mCycle;
      end else if (mPhase == PH_GAP && timer == GAPLEN - 1) begin
        newPhase = PH_IDLE;
        newEntered = mCycle;
      end

      newHigh  = mDet ? mHighRun + 1 : 0;
      newFault = mFault || (FAULT_EN && newHigh >= STUCK);

      mDet      = newDet;
      mRisePrev = newRise;
      mGreenRun = newRun;
      mVeh      = newVeh;
      mPhase    = newPhase;
      mEntered  = newEntered;
      mHighRun  = newHigh;
      mFault    = newFault;
      for (int j = 0; j < 5; j++) rawHist[j] = rawHist[j+1];
      rawHist[5] = bus.raw_sense;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input bit raw, input bit green, input bit rst);
    bus.raw_sense  = raw;
    bus.side_green = green;
    Dreset         = rst;
    tick();
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_dss"},   32'(bus.Dss),     32'(mDss()));
    checkValue({tag, "_veh"},   32'(bus.veh_cnt), 32'(mVeh));
    checkValue({tag, "_fault"}, 32'(bus.fault),   32'(mFault));
  endtask

  function automatic bit mDss();
    return (mPhase == PH_REQ);
  endfunction

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic arrivals(input int count);
    for (int a = 0; a < count; a++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus(i < 8, 1'b0, 1'b0);
        checkOutput("arr");
      end
    end
  endtask

  typedef struct {
    bit raw;
    bit green;
    bit expDss;
    int expVeh;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int zeros;
    int prev;
    int rawLeft;
    int greenLeft;
    bit rawVal;
    bit greenVal;

    // raw_sense held high from edge e0: det at e5, count at e6, request at e7
    vecs[0] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1};

    bus.raw_sense  = 1'b0;
    bus.side_green = 1'b0;
    Dreset         = 1'b1;

    doReset(3);
    checkValue("reset_dss",   32'(bus.Dss),     32'd0);
    checkValue("reset_veh",   32'(bus.veh_cnt), 32'd0);
    checkValue("reset_fault", 32'(bus.fault),   32'd0);

    $display("[TB] latency table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].raw, vecs[i].green, 1'b0);
      checkValue($sformatf("lat_dss_e%0d", i), 32'(bus.Dss),     32'(vecs[i].expDss));
      checkValue($sformatf("lat_veh_e%0d", i), 32'(bus.veh_cnt), 32'(vecs[i].expVeh));
      checkOutput("lat");
    end

    $display("[TB] glitch rejection");
    doReset(2);
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w + 10; i++) begin
        applyStimulus(i < w, 1'b0, 1'b0);
        checkOutput("glitch");
      end
      checkValue($sformatf("glitch%0d_veh", w), 32'(bus.veh_cnt), 32'd0);
      checkValue($sformatf("glitch%0d_dss", w), 32'(bus.Dss),     32'd0);
    end

    $display("[TB] departures and gap");
    doReset(2);
    arrivals(3);
    checkValue("dep_start_veh", 32'(bus.veh_cnt), 32'd3);
    checkValue("dep_start_dss", 32'(bus.Dss),     32'd1);
    for (int d = 0; d < 3; d++) begin
      n = 0;
      prev = int'(bus.veh_cnt);
      do begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("dep");
        n++;
      end while (int'(bus.veh_cnt) == prev && n < 20);
      checkValue($sformatf("dep_period%0d", d), 32'(n), 32'(DEPART));
      checkValue($sformatf("dep_veh%0d", d), 32'(bus.veh_cnt), 32'(2 - d));
    end
    checkValue("dep_dss_before_drop", 32'(bus.Dss), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("drop");
    checkValue("dep_dss_drop", 32'(bus.Dss), 32'd0);

    // arrival inside the gap must not raise Dss until the gap is over
    zeros = 0;
    n = 0;
    while (n < 60) begin
      applyStimulus(n >= 2 && n < 10, 1'b0, 1'b0);
      checkOutput("gap");
      if (n == 15) begin
        checkValue("gap_veh_counted", 32'(bus.veh_cnt), 32'd1);
        checkValue("gap_dss_low",     32'(bus.Dss),     32'd0);
      end
      n++;
      if (bus.Dss === 1'b1) break;
      zeros++;
    end
    checkValue("gap_zero_cycles", 32'(zeros), 32'(GAPLEN));

    $display("[TB] saturation and coincident events");
    doReset(2);
    arrivals(20);
    checkValue("sat_veh", 32'(bus.veh_cnt), 32'(VEH_MAX));
    for (int i = 0; i < 24; i++) begin
      applyStimulus(i >= 9 && i < 15, 1'b1, 1'b0);
      checkOutput("coin");
      if (i == 6)  checkValue("coin_before_dep", 32'(bus.veh_cnt), 32'd15);
      if (i == 7)  checkValue("coin_first_dep",  32'(bus.veh_cnt), 32'd14);
      if (i == 15) checkValue("coin_cancel",     32'(bus.veh_cnt), 32'd14);
      if (i == 23) checkValue("coin_third_dep",  32'(bus.veh_cnt), 32'd13);
    end

    $display("[TB] reset during request");
    doReset(2);
    n = 0;
    do begin
      applyStimulus(n < 8, 1'b0, 1'b0);
      checkOutput("rreq");
      n++;
    end while (bus.Dss !== 1'b1 && n < 40);
    checkValue("rreq_reached", 32'(bus.Dss), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("rreq");
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("rreq_dss",   32'(bus.Dss),     32'd0);
    checkValue("rreq_veh",   32'(bus.veh_cnt), 32'd0);
    checkValue("rreq_fault", 32'(bus.fault),   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rreq_after");

    $display("[TB] stuck sensor");
    doReset(2);
`ifdef SENSOR_FAULT_DET_EN
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stuck");
      n++;
    end while (bus.fault !== 1'b1 && n < 400);
    checkValue("stuck_latency", 32'(n), 32'd262);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stuck");
    end
    checkValue("stuck_dss",   32'(bus.Dss),     32'd0);
    checkValue("stuck_veh",   32'(bus.veh_cnt), 32'd0);
    checkValue("stuck_fault", 32'(bus.fault),   32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("stuck_clear", 32'(bus.fault), 32'd0);
`else
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stuck");
    end
    checkValue("stuck_fault", 32'(bus.fault),   32'd0);
    checkValue("stuck_veh",   32'(bus.veh_cnt), 32'd1);
    checkValue("stuck_dss",   32'(bus.Dss),     32'd1);
`endif

    $display("[TB] randomized run");
    doReset(2);
    rawLeft = 0;
    greenLeft = 0;
    rawVal = 1'b0;
    greenVal = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rawLeft == 0) begin
        rawVal = ~rawVal;
        rawLeft = $urandom_range(1, 10);
      end
      if (greenLeft == 0) begin
        greenVal = 1'($urandom_range(0, 1));
        greenLeft = $urandom_range(1, 40);
      end
      rawLeft--;
      greenLeft--;
      applyStimulus(rawVal, greenVal, $urandom_range(0, 999) == 0);
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
